ahb_sram: RTL

//  AHB-Lite slave holding on-chip program/data SRAM; occupies bus device slot 0 (0x000-0x7FF).

---
 rtl/ahb_sram_pkg.sv | 52 +++++
 rtl/ahb_sram_array.sv | 31 +++
 rtl/ahb_sram.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ahb_sram_pkg.sv
// Shared AHB-Lite bus types for the on-chip SRAM slave, plus helpers that
// derive write byte lanes and alignment legality from HSIZE and the low
// address bits.
package ahb_sram_pkg;

    typedef enum logic [2:0] {
        SIZE_BYTE = 3'd0,
        SIZE_HALF = 3'd1,
        SIZE_WORD = 3'd2
    } transfer_size;

    typedef enum logic [1:0] {
        KIND_IDLE   = 2'd0,
        KIND_BUSY   = 2'd1,
        KIND_NONSEQ = 2'd2,
        KIND_SEQ    = 2'd3
    } transfer_kind;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } transfer_response;

    localparam int BUS_DATA_W = 32;

    // Little-endian lane enables; sizes above WORD enable nothing.
    function automatic logic [3:0] byte_enables(transfer_size size, logic [1:0] lo);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SIZE_BYTE: be = 4'b0001 << lo;
            SIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    // A transfer is legal only when naturally aligned and no wider than a word.
    function automatic logic is_aligned(transfer_size size, logic [1:0] lo);
        logic ok;
        ok = 1'b0;
        case (size)
            SIZE_BYTE: ok = 1'b1;
            SIZE_HALF: ok = (lo[0] == 1'b0);
            SIZE_WORD: ok = (lo == 2'b00);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// DEPTH_WORDS x 32 storage with a byte-enable write port and an
// asynchronous read port. Contents are never cleared by reset.
module ahb_sram_array #(
    parameter int    DEPTH_WORDS = 512,
    parameter string INIT_FILE   = "",
    localparam int   AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // Commit the enabled byte lanes of the addressed word.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_sram.sv
// AHB-Lite SRAM slave for device slot 0. Address phase is latched when the
// bus is ready; the data phase answers in DATA, optionally after wait
// states, or with the two-cycle ERROR response for misaligned/oversized
// accesses. Optional feature macro: AHB_SRAM_WAIT_EN (wait-state insertion).
module ahb_sram
    import ahb_sram_pkg::*;
#(
    parameter int    DEPTH_WORDS = 512,
    parameter int    WAIT_CYCLES = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             sel_i,
    input  logic [31:0]      addr_i,
    input  logic             write_i,
    input  transfer_size     size_i,
    input  transfer_kind     trans_i,
    input  logic             ready_in_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o,
    output logic             ready_out_o,
    output transfer_response resp_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
`ifdef AHB_SRAM_WAIT_EN
        , ST_WAIT
`endif
    } state_e;

    state_e       state_q, state_d;
    logic [AW-1:0] idx_q;
    logic [1:0]   lo_q;
    logic         write_q;
    transfer_size size_q;
    logic         accept;
    logic         latch;
    logic [31:0]  mem_rdata;
    logic         unused_addr;

`ifdef AHB_SRAM_WAIT_EN
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
`endif

    // Upper address bits belong to the decoder.
    assign unused_addr = ^addr_i[31:AW+2];

    assign accept = sel_i && ready_in_i &&
                    ((trans_i == KIND_NONSEQ) || (trans_i == KIND_SEQ));

    // Next-state: new phases are only sampled in states that drive ready high.
    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
`ifdef AHB_SRAM_WAIT_EN
        wait_cnt_d = wait_cnt_q;
`endif
        case (state_q)
            ST_ERR1: state_d = ST_ERR2;
`ifdef AHB_SRAM_WAIT_EN
            ST_WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d = ST_DATA;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    latch = 1'b1;
                    if (!is_aligned(size_i, addr_i[1:0])) begin
                        state_d = ST_ERR1;
                    end else begin
`ifdef AHB_SRAM_WAIT_EN
                        if (WAIT_CYCLES > 0) begin
                            state_d    = ST_WAIT;
                            wait_cnt_d = CW'(WAIT_CYCLES - 1);
                        end else begin
                            state_d = ST_DATA;
                        end
`else
                        state_d = ST_DATA;
`endif
                    end
                end
            end
        endcase
    end

    // State and latched address-phase attributes.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            lo_q    <= 2'b00;
            write_q <= 1'b0;
            size_q  <= SIZE_BYTE;
`ifdef AHB_SRAM_WAIT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
`ifdef AHB_SRAM_WAIT_EN
            wait_cnt_q <= wait_cnt_d;
`endif
            if (latch) begin
                idx_q   <= addr_i[AW+1:2];
                lo_q    <= addr_i[1:0];
                write_q <= write_i;
                size_q  <= size_i;
            end
        end
    end

    // Response outputs are a pure function of the state.
    always_comb begin
        ready_out_o = 1'b1;
        resp_o      = RESP_OKAY;
        rdata_o     = '0;
        case (state_q)
            ST_ERR1: begin
                ready_out_o = 1'b0;
                resp_o      = RESP_ERROR;
            end
            ST_ERR2: resp_o = RESP_ERROR;
            ST_DATA: if (!write_q) rdata_o = mem_rdata;
`ifdef AHB_SRAM_WAIT_EN
            ST_WAIT: ready_out_o = 1'b0;
`endif
            default: ;
        endcase
    end

    ahb_sram_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .INIT_FILE  (INIT_FILE)
    ) u_array (
        .clk_i  (clock_i),
        .we_i   ((state_q == ST_DATA) && write_q),
        .be_i   (byte_enables(size_q, lo_q)),
        .addr_i (idx_q),
        .wdata_i(wdata_i),
        .rdata_o(mem_rdata)
    );

endmodule
